// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment PWM display driver.
package seg7_pkg;

    localparam int unsigned VALUE_W = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned PWM_W   = 3;
    localparam int unsigned HOLD_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SHOW = 2'd2
    } state_e;

    // Segment patterns, a..g on bits 0..6, active high
    localparam logic [SEG_W-1:0] GLYPH_0    = 7'h3F;
    localparam logic [SEG_W-1:0] GLYPH_1    = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_2    = 7'h5B;
    localparam logic [SEG_W-1:0] GLYPH_3    = 7'h4F;
    localparam logic [SEG_W-1:0] GLYPH_4    = 7'h66;
    localparam logic [SEG_W-1:0] GLYPH_5    = 7'h6D;
    localparam logic [SEG_W-1:0] GLYPH_6    = 7'h7D;
    localparam logic [SEG_W-1:0] GLYPH_7    = 7'h07;
    localparam logic [SEG_W-1:0] GLYPH_8    = 7'h7F;
    localparam logic [SEG_W-1:0] GLYPH_9    = 7'h6F;
    localparam logic [SEG_W-1:0] GLYPH_A    = 7'h77;
    localparam logic [SEG_W-1:0] GLYPH_B    = 7'h7C;
    localparam logic [SEG_W-1:0] GLYPH_C    = 7'h39;
    localparam logic [SEG_W-1:0] GLYPH_D    = 7'h5E;
    localparam logic [SEG_W-1:0] GLYPH_E    = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_F    = 7'h71;
    localparam logic [SEG_W-1:0] GLYPH_DASH = 7'h40;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to seven-segment glyph decode.
// Option: define SEG7_HEX_EN to show A..F for 10..15; otherwise those show a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [VALUE_W-1:0] value,
    output logic [SEG_W-1:0]   seg_c
);

    // Glyph lookup
    always_comb begin
        seg_c = GLYPH_DASH;
        case (value)
            4'd0: seg_c = GLYPH_0;
            4'd1: seg_c = GLYPH_1;
            4'd2: seg_c = GLYPH_2;
            4'd3: seg_c = GLYPH_3;
            4'd4: seg_c = GLYPH_4;
            4'd5: seg_c = GLYPH_5;
            4'd6: seg_c = GLYPH_6;
            4'd7: seg_c = GLYPH_7;
            4'd8: seg_c = GLYPH_8;
            4'd9: seg_c = GLYPH_9;
`ifdef SEG7_HEX_EN
            4'd10: seg_c = GLYPH_A;
            4'd11: seg_c = GLYPH_B;
            4'd12: seg_c = GLYPH_C;
            4'd13: seg_c = GLYPH_D;
            4'd14: seg_c = GLYPH_E;
            4'd15: seg_c = GLYPH_F;
`endif
            default: seg_c = GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_pwm_driver.sv
// Seven-segment display driver: valid/ready value intake with minimum hold,
// PWM brightness gating on the segments and a wrap flag on the decimal point.
// Option: SEG7_HEX_EN (carried by seg7_decode) enables hex glyphs for 10..15.
module seg7_pwm_driver
    import seg7_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VALUE_W-1:0] value_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [PWM_W-1:0]   bright_i,
    output logic [SEG_W-1:0]   seg_o,
    output logic               dp_o
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic [PWM_W-1:0]   pwm_q;
    logic               accept_c;
    logic               dp_d;
    logic               ready_d;
    logic [SEG_W-1:0]   seg_d;
    logic [SEG_W-1:0]   glyph_c;

    seg7_decode u_decode (
        .value (value_q),
        .seg_c (glyph_c)
    );

    // FSM, hold timer and latched value registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            value_q <= value_d;
        end
    end

    // Next state, hold countdown, wrap detection and output next values
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        value_d  = value_q;
        dp_d     = dp_o;
        accept_c = valid_i && ready_o;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_LOAD;
                    value_d = value_i;
                    dp_d    = 1'b0;
                end
            end
            ST_HOLD: begin
                if (hold_q <= HOLD_W'(1)) begin
                    state_d = ST_SHOW;
                    hold_d  = '0;
                    dp_d    = 1'b0;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_SHOW: begin
                if (accept_c) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_LOAD;
                    value_d = value_i;
                    dp_d    = (value_i < value_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
                dp_d    = 1'b0;
            end
        endcase
        ready_d = (state_d != ST_HOLD);
        seg_d   = ((state_q != ST_IDLE) && (pwm_q < bright_i)) ? glyph_c : '0;
    end

    // Free-running brightness PWM counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_q + PWM_W'(1);
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_o <= 1'b1;
            seg_o   <= '0;
            dp_o    <= 1'b0;
        end else begin
            ready_o <= ready_d;
            seg_o   <= seg_d;
            dp_o    <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg7_pwm_driver.sv
// Self-checking bench for seg7_pwm_driver with a cycle-level reference model.
module tb_seg7_pwm_driver;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] value_i;
    logic       valid_i;
    logic       ready_o;
    logic [2:0] bright_i;
    logic [6:0] seg_o;
    logic       dp_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_cyc;
    bit         m_has;
    int         m_val;
    int         m_busy;
    bit         m_dp;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_ready;

    seg7_pwm_driver #(.HOLD_CYCLES(H)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value_i  (value_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .bright_i (bright_i),
        .seg_o    (seg_o),
        .dp_o     (dp_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] ref_glyph(input int v);
        case (v)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
`ifdef SEG7_HEX_EN
            10: return 7'h77;
            11: return 7'h7C;
            12: return 7'h39;
            13: return 7'h5E;
            14: return 7'h79;
            15: return 7'h71;
`endif
            default: return 7'h40;
        endcase
    endfunction

    task automatic model_reset();
        m_cyc     = 0;
        m_has     = 1'b0;
        m_val     = 0;
        m_busy    = 0;
        m_dp      = 1'b0;
        exp_seg   = 7'h00;
        exp_dp    = 1'b0;
        exp_ready = 1'b1;
    endtask

    // Drive one cycle of inputs, advance the model, sample 1ns after the edge
    task automatic tick(input logic [3:0] v, input logic vl, input logic [2:0] b);
        bit acc;
        value_i  = v;
        valid_i  = vl;
        bright_i = b;
        acc = vl && (m_busy == 0);
        exp_seg = (m_has && ((m_cyc % 8) < int'(b))) ? ref_glyph(m_val) : 7'h00;
        m_cyc++;
        if (acc) begin
            m_dp   = m_has && (int'(v) < m_val);
            m_busy = H;
            m_val  = int'(v);
            m_has  = 1'b1;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) m_dp = 1'b0;
        end
        exp_ready = (m_busy == 0);
        exp_dp    = m_dp;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_i = 1'b1; value_i = 4'd9; bright_i = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (seg_o !== 7'h00) begin n_fail++; $display("FAIL reset_seg got=%h exp=00", seg_o); end
        n_checks++;
        if (dp_o !== 1'b0) begin n_fail++; $display("FAIL reset_dp got=%b exp=0", dp_o); end
        n_checks++;
        if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        valid_i = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        int low_cnt = 0;
        int on_cnt  = 0;
        tick(4'd3, 1'b1, 3'd7);
        n_checks++;
        if (seg_o !== exp_seg || dp_o !== exp_dp || ready_o !== exp_ready) begin
            n_fail++;
            $display("FAIL basic_accept seg=%h/%h dp=%b/%b rdy=%b/%b", seg_o, exp_seg, dp_o, exp_dp, ready_o, exp_ready);
        end
        if (ready_o === 1'b0) low_cnt++;
        for (int i = 0; i < 16; i++) begin
            tick(4'd3, 1'b0, 3'd7);
            n_checks++;
            if (seg_o !== exp_seg || dp_o !== exp_dp || ready_o !== exp_ready) begin
                n_fail++;
                $display("FAIL basic_cyc%0d seg=%h/%h dp=%b/%b rdy=%b/%b", i, seg_o, exp_seg, dp_o, exp_dp, ready_o, exp_ready);
            end
            if (ready_o === 1'b0) low_cnt++;
            if (i >= 8 && seg_o === 7'h4F) on_cnt++;
        end
        n_checks++;
        if (low_cnt != H) begin n_fail++; $display("FAIL basic_ready_low got=%0d exp=%0d", low_cnt, H); end
        n_checks++;
        if (on_cnt != 7) begin n_fail++; $display("FAIL basic_duty got=%0d exp=7", on_cnt); end
    endtask

    task automatic test_continuous();
        int dut_acc = 0;
        for (int i = 0; i < 30; i++) begin
            if (ready_o === 1'b1) dut_acc++;
            tick(4'd5, 1'b1, 3'd7);
            n_checks++;
            if (seg_o !== exp_seg || dp_o !== exp_dp || ready_o !== exp_ready) begin
                n_fail++;
                $display("FAIL cont_cyc%0d seg=%h/%h dp=%b/%b rdy=%b/%b", i, seg_o, exp_seg, dp_o, exp_dp, ready_o, exp_ready);
            end
        end
        n_checks++;
        if (dut_acc != (30 + H) / (H + 1)) begin
            n_fail++;
            $display("FAIL cont_accepts got=%0d exp=%0d", dut_acc, (30 + H) / (H + 1));
        end
        for (int i = 0; i <= H; i++) tick(4'd5, 1'b0, 3'd7);
    endtask

    task automatic test_wrap();
        int dp_cnt = 0;
        tick(4'd15, 1'b1, 3'd7);
        for (int i = 0; i < H; i++) tick(4'd0, 1'b0, 3'd7);
        tick(4'd0, 1'b1, 3'd7);
        if (dp_o === 1'b1) dp_cnt++;
        for (int i = 0; i < H; i++) begin
            tick(4'd0, 1'b0, 3'd7);
            n_checks++;
            if (seg_o !== exp_seg || dp_o !== exp_dp || ready_o !== exp_ready) begin
                n_fail++;
                $display("FAIL wrap_cyc%0d seg=%h/%h dp=%b/%b rdy=%b/%b", i, seg_o, exp_seg, dp_o, exp_dp, ready_o, exp_ready);
            end
            if (dp_o === 1'b1) dp_cnt++;
        end
        n_checks++;
        if (dp_cnt != H) begin n_fail++; $display("FAIL wrap_dp_cycles got=%0d exp=%0d", dp_cnt, H); end
        tick(4'd1, 1'b1, 3'd7);
        n_checks++;
        if (dp_o !== 1'b0 || ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL nowrap_dp dp=%b exp=0 rdy=%b exp=0", dp_o, ready_o);
        end
        for (int i = 0; i < H; i++) tick(4'd1, 1'b0, 3'd7);
    endtask

    task automatic test_bright();
        int on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick(4'd1, 1'b0, 3'd0);
            n_checks++;
            if (seg_o !== 7'h00) begin n_fail++; $display("FAIL bright0_cyc%0d got=%h exp=00", i, seg_o); end
        end
        for (int i = 0; i < 16; i++) begin
            tick(4'd1, 1'b0, 3'd2);
            n_checks++;
            if (seg_o !== exp_seg) begin n_fail++; $display("FAIL bright2_cyc%0d got=%h exp=%h", i, seg_o, exp_seg); end
            if (seg_o === 7'h06) on_cnt++;
        end
        n_checks++;
        if (on_cnt != 4) begin n_fail++; $display("FAIL bright2_duty got=%0d exp=4", on_cnt); end
    endtask

    task automatic test_hex();
        logic [6:0] want;
        int on_cnt = 0;
`ifdef SEG7_HEX_EN
        want = 7'h39;
`else
        want = 7'h40;
`endif
        tick(4'd12, 1'b1, 3'd7);
        for (int i = 0; i < 8; i++) begin
            tick(4'd12, 1'b0, 3'd7);
            if (seg_o === want) on_cnt++;
        end
        n_checks++;
        if (on_cnt != 7) begin n_fail++; $display("FAIL hex12 glyph cycles got=%0d exp=7 (glyph %h, seg=%h)", on_cnt, want, seg_o); end
    endtask

    task automatic test_reset_mid_hold();
        tick(4'd7, 1'b1, 3'd7);
        tick(4'd7, 1'b0, 3'd7);
        tick(4'd7, 1'b0, 3'd7);
        n_checks++;
        if (dp_o !== 1'b1 || ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midhold_pre dp=%b exp=1 rdy=%b exp=0", dp_o, ready_o);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (seg_o !== 7'h00 || dp_o !== 1'b0 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midhold_async seg=%h/00 dp=%b/0 rdy=%b/1", seg_o, dp_o, ready_o);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        tick(4'd2, 1'b1, 3'd7);
        n_checks++;
        if (dp_o !== 1'b0 || ready_o !== 1'b0 || seg_o !== 7'h00) begin
            n_fail++;
            $display("FAIL midhold_first_accept dp=%b/0 rdy=%b/0 seg=%h/00", dp_o, ready_o, seg_o);
        end
        for (int i = 0; i < H; i++) begin
            tick(4'd2, 1'b0, 3'd7);
            n_checks++;
            if (seg_o !== exp_seg || dp_o !== 1'b0 || ready_o !== exp_ready) begin
                n_fail++;
                $display("FAIL midhold_cyc%0d seg=%h/%h dp=%b/0 rdy=%b/%b", i, seg_o, exp_seg, dp_o, ready_o, exp_ready);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            tick(4'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)));
            n_checks++;
            if (seg_o !== exp_seg || dp_o !== exp_dp || ready_o !== exp_ready) begin
                n_fail++;
                $display("FAIL random_cyc%0d seg=%h/%h dp=%b/%b rdy=%b/%b", i, seg_o, exp_seg, dp_o, exp_dp, ready_o, exp_ready);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; value_i = 4'd0; valid_i = 1'b0; bright_i = 3'd0;
        model_reset();
        test_reset();
        test_basic();
        test_continuous();
        test_wrap();
        test_bright();
        test_hex();
        test_reset_mid_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
